// File: rtl/c1541_gcr_track_sched.sv
// Track-buffer scheduler for the direct-GCR 1541: settles on a head position, writes back the dirty
// track and loads the new one over the SD block interface while stalling the GCR engine via busy.
module c1541_gcr_track_sched #(
   parameter int TRACK_BLOCKS = 16,
   parameter int HALF_TRACKS  = 84,
   parameter int SETTLE_CLKS  = 16000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        img_mounted,
   input  logic [31:0] img_size,
   input  logic        img_readonly,
   input  logic [6:0]  half_track,
   input  logic        mtr,
   input  logic        drv_we,
   output logic        busy,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   output logic [6:0]  cur_track,
   output logic        track_valid,
   output logic        dirty
);
   localparam int BLK_W = (TRACK_BLOCKS > 1) ? $clog2(TRACK_BLOCKS) : 1;
   localparam int SC_W  = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;

   typedef enum logic [2:0] {IDLE, SETTLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

   state_t            state_q, state_d;
   logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic [6:0]        settle_tgt_q, settle_tgt_d;
   logic              flush_only_q, flush_only_d;
   logic [6:0]        new_track_q, new_track_d;
   logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
   logic              busy_q, busy_d;
   logic              sd_rd_q, sd_rd_d;
   logic              sd_wr_q, sd_wr_d;
   logic [31:0]       sd_lba_q, sd_lba_d;
   logic [6:0]        cur_track_q, cur_track_d;
   logic              track_valid_q, track_valid_d;
   logic              dirty_q, dirty_d;
   logic              has_img_q, has_img_d;
   logic              ro_q, ro_d;
   logic              mount_pend_q, mount_pend_d;
   logic              ack_q;

   logic [6:0]        tgt;
   logic              ack_fall;
   logic              last_blk;
   logic              abort_pend;
   logic [BLK_W-1:0]  blk_nxt;

   function automatic logic [31:0] lba_of(input logic [6:0] slot, input logic [BLK_W-1:0] blk);
      return {25'b0, slot} * 32'(TRACK_BLOCKS) + 32'(blk);
   endfunction

   assign tgt        = (half_track > 7'(HALF_TRACKS - 1)) ? 7'(HALF_TRACKS - 1) : half_track;
   assign ack_fall   = ack_q & ~sd_ack;
   assign last_blk   = (blk_cnt_q == BLK_W'(TRACK_BLOCKS - 1));
   assign abort_pend = mount_pend_q | img_mounted;
   assign blk_nxt    = blk_cnt_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      settle_cnt_d  = settle_cnt_q;
      settle_tgt_d  = settle_tgt_q;
      flush_only_d  = flush_only_q;
      new_track_d   = new_track_q;
      blk_cnt_d     = blk_cnt_q;
      busy_d        = busy_q;
      sd_rd_d       = sd_rd_q;
      sd_wr_d       = sd_wr_q;
      sd_lba_d      = sd_lba_q;
      cur_track_d   = cur_track_q;
      track_valid_d = track_valid_q;
      dirty_d       = dirty_q;
      has_img_d     = has_img_q;
      ro_d          = ro_q;
      mount_pend_d  = mount_pend_q;

      // A mount during a transfer is deferred to the next block boundary so the SD host never sees a torn block.
      if (img_mounted) begin
         has_img_d = (img_size != 32'd0);
         ro_d      = img_readonly;
         if (busy_q) begin
            mount_pend_d = 1'b1;
         end else begin
            track_valid_d = 1'b0;
            dirty_d       = 1'b0;
         end
      end else if (drv_we && has_img_q && !ro_q && track_valid_q) begin
         dirty_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (img_mounted) begin
               state_d = IDLE;
            end else if (has_img_q && (!track_valid_q || tgt != cur_track_q)) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
               settle_tgt_d = tgt;
               flush_only_d = 1'b0;
            end else if (dirty_q && !mtr) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
               settle_tgt_d = tgt;
               flush_only_d = 1'b1;
            end
         end
         SETTLE: begin
            if (img_mounted || (flush_only_q && mtr)) begin
               state_d = IDLE;
            end else if (!flush_only_q && tgt != settle_tgt_q) begin
               settle_cnt_d = '0;
               settle_tgt_d = tgt;
            end else if (settle_cnt_q == SC_W'(SETTLE_CLKS - 1)) begin
               new_track_d = tgt;
               blk_cnt_d   = '0;
               busy_d      = 1'b1;
               if (dirty_q) begin
                  state_d  = WR_REQ;
                  sd_wr_d  = 1'b1;
                  sd_lba_d = lba_of(cur_track_q, '0);
               end else begin
                  state_d  = RD_REQ;
                  sd_rd_d  = 1'b1;
                  sd_lba_d = lba_of(tgt, '0);
               end
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         WR_REQ, RD_REQ: begin
            if (sd_ack) begin
               sd_wr_d = 1'b0;
               sd_rd_d = 1'b0;
               state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
            end else if (abort_pend) begin
               state_d       = IDLE;
               sd_rd_d       = 1'b0;
               sd_wr_d       = 1'b0;
               busy_d        = 1'b0;
               track_valid_d = 1'b0;
               dirty_d       = 1'b0;
               mount_pend_d  = 1'b0;
            end
         end
         WR_WAIT: begin
            if (ack_fall) begin
               if (abort_pend) begin
                  state_d       = IDLE;
                  busy_d        = 1'b0;
                  track_valid_d = 1'b0;
                  dirty_d       = 1'b0;
                  mount_pend_d  = 1'b0;
               end else if (last_blk) begin
                  dirty_d   = 1'b0;
                  blk_cnt_d = '0;
                  if (flush_only_q) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     state_d  = RD_REQ;
                     sd_rd_d  = 1'b1;
                     sd_lba_d = lba_of(new_track_q, '0);
                  end
               end else begin
                  blk_cnt_d = blk_nxt;
                  state_d   = WR_REQ;
                  sd_wr_d   = 1'b1;
                  sd_lba_d  = lba_of(cur_track_q, blk_nxt);
               end
            end
         end
         RD_WAIT: begin
            if (ack_fall) begin
               if (abort_pend) begin
                  state_d       = IDLE;
                  busy_d        = 1'b0;
                  track_valid_d = 1'b0;
                  dirty_d       = 1'b0;
                  mount_pend_d  = 1'b0;
               end else if (last_blk) begin
                  state_d       = IDLE;
                  blk_cnt_d     = '0;
                  busy_d        = 1'b0;
                  cur_track_d   = new_track_q;
                  track_valid_d = 1'b1;
               end else begin
                  blk_cnt_d = blk_nxt;
                  state_d   = RD_REQ;
                  sd_rd_d   = 1'b1;
                  sd_lba_d  = lba_of(new_track_q, blk_nxt);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         settle_cnt_q  <= '0;
         settle_tgt_q  <= '0;
         flush_only_q  <= 1'b0;
         new_track_q   <= '0;
         blk_cnt_q     <= '0;
         busy_q        <= 1'b0;
         sd_rd_q       <= 1'b0;
         sd_wr_q       <= 1'b0;
         sd_lba_q      <= '0;
         cur_track_q   <= '0;
         track_valid_q <= 1'b0;
         dirty_q       <= 1'b0;
         has_img_q     <= 1'b0;
         ro_q          <= 1'b0;
         mount_pend_q  <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         settle_cnt_q  <= settle_cnt_d;
         settle_tgt_q  <= settle_tgt_d;
         flush_only_q  <= flush_only_d;
         new_track_q   <= new_track_d;
         blk_cnt_q     <= blk_cnt_d;
         busy_q        <= busy_d;
         sd_rd_q       <= sd_rd_d;
         sd_wr_q       <= sd_wr_d;
         sd_lba_q      <= sd_lba_d;
         cur_track_q   <= cur_track_d;
         track_valid_q <= track_valid_d;
         dirty_q       <= dirty_d;
         has_img_q     <= has_img_d;
         ro_q          <= ro_d;
         mount_pend_q  <= mount_pend_d;
         ack_q         <= sd_ack;
      end
   end

   assign busy        = busy_q;
   assign sd_rd       = sd_rd_q;
   assign sd_wr       = sd_wr_q;
   assign sd_lba      = sd_lba_q;
   assign cur_track   = cur_track_q;
   assign track_valid = track_valid_q;
   assign dirty       = dirty_q;

endmodule
